// File: rtl/tcdm_traffic_checker.sv
// Self-checking TCDM master: writes an LFSR pattern to N_WORDS words, reads it back and counts mismatches.
// Requests are issued back-to-back with in-order responses tracked by an outstanding counter and expected-data FIFO.
module tcdm_traffic_checker #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned N_WORDS   = 64,
    parameter logic [31:0] SEED      = 32'h1,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] first_err_addr_o,
    output logic        tcdm_req_o,
    input  logic        tcdm_gnt_i,
    output logic [31:0] tcdm_add_o,
    output logic        tcdm_wen_o,
    output logic [3:0]  tcdm_be_o,
    output logic [31:0] tcdm_data_o,
    input  logic        tcdm_r_valid_i,
    input  logic [31:0] tcdm_r_data_i
);

    localparam int unsigned IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [31:0]   SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_WORDS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [OW-1:0] OUT_FULL = OW'(MAX_OUT);
    localparam logic [OW-1:0] OUT_ONE  = OW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [OW-1:0] out_q, out_d;
    logic [31:0]   lfsr_q, lfsr_nxt;
    logic [15:0]   err_cnt_q;
    logic [31:0]   first_err_q;
    logic          first_err_vld_q;
    logic [63:0]   fifo_mem [MAX_OUT];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;

    logic          issuing, busy, req, hs, rsp, spur, pop, mismatch, last, start_ok;
    logic [31:0]   addr;
    logic [63:0]   head;

    always_comb begin
        issuing  = (state_q == S_WRITE) || (state_q == S_READ);
        busy     = issuing || (state_q == S_WDRAIN) || (state_q == S_RDRAIN);
        // A response in the same cycle frees a slot, so a full window may still issue.
        req      = issuing && ((out_q != OUT_FULL) || tcdm_r_valid_i);
        hs       = req && tcdm_gnt_i;
        rsp      = busy && tcdm_r_valid_i && (out_q != '0);
        spur     = busy && tcdm_r_valid_i && (out_q == '0);
        pop      = rsp && ((state_q == S_READ) || (state_q == S_RDRAIN));
        head     = fifo_mem[rd_ptr_q];
        mismatch = pop && (head[63:32] != tcdm_r_data_i);
        last     = (idx_q == IDX_LAST);
        start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
        addr     = BASE_ADDR + (32'(idx_q) << 2);
        lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h80200003 : 32'h0);

        out_d = out_q;
        if (hs && !rsp) begin
            out_d = out_q + OUT_ONE;
        end else if (!hs && rsp) begin
            out_d = out_q - OUT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) state_d = S_WRITE;
            S_WRITE:        if (hs && last) state_d = S_WDRAIN;
            S_WDRAIN:       if (out_d == '0) state_d = S_READ;
            S_READ:         if (hs && last) state_d = S_RDRAIN;
            S_RDRAIN:       if (out_d == '0) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            out_q           <= '0;
            lfsr_q          <= SEED_EFF;
            err_cnt_q       <= '0;
            first_err_q     <= '0;
            first_err_vld_q <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (start_ok) begin
                idx_q           <= '0;
                lfsr_q          <= SEED_EFF;
                err_cnt_q       <= '0;
                first_err_q     <= '0;
                first_err_vld_q <= 1'b0;
                rd_ptr_q        <= '0;
                wr_ptr_q        <= '0;
            end else begin
                if (hs) begin
                    idx_q  <= last ? '0 : idx_q + IDX_ONE;
                    lfsr_q <= lfsr_nxt;
                end
                // The read phase regenerates the same sequence from the seed.
                if (state_q == S_WDRAIN && state_d == S_READ) begin
                    idx_q  <= '0;
                    lfsr_q <= SEED_EFF;
                end
                if (hs && state_q == S_READ) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
                end
                if ((mismatch || spur) && err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
                if (mismatch && !first_err_vld_q) begin
                    first_err_q     <= head[31:0];
                    first_err_vld_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs && state_q == S_READ) begin
            fifo_mem[wr_ptr_q] <= {lfsr_q, addr};
        end
    end

    assign busy_o           = busy;
    assign done_o           = (state_q == S_DONE);
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign tcdm_req_o       = req;
    assign tcdm_add_o       = issuing ? addr : 32'h0;
    assign tcdm_wen_o       = (state_q == S_READ);
    assign tcdm_be_o        = {4{issuing}};
    assign tcdm_data_o      = (state_q == S_WRITE) ? lfsr_q : 32'h0;

endmodule

// File: tb/tb_tcdm_traffic_checker.sv
// Bench for tcdm_traffic_checker: random-stall memory with in-order delayed responses and a transaction-level model.
module tb_tcdm_traffic_checker;

    localparam int          N    = 16;
    localparam int          MO   = 4;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] SEED = 32'h1;

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done;
    logic [15:0] err_cnt;
    logic [31:0] first_err;
    logic        req, gnt, wen, rvalid;
    logic [31:0] add, wdata, rdata;
    logic [3:0]  be;

    always #5 clk = ~clk;

    tcdm_traffic_checker #(
        .BASE_ADDR(BASE), .N_WORDS(N), .SEED(SEED), .MAX_OUT(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .err_cnt_o(err_cnt), .first_err_addr_o(first_err),
        .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
        .tcdm_be_o(be), .tcdm_data_o(wdata), .tcdm_r_valid_i(rvalid), .tcdm_r_data_i(rdata)
    );

    typedef struct {
        int          due;
        logic [31:0] dat;
        bit          rd;
        int          idx;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] mem [N];
    logic [31:0] pat [N];
    logic [31:0] cap [3];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    bit          run;
    int          wr_hs, rd_hs, outst, exp_err, max_out;
    logic [31:0] exp_first;
    bit          exp_first_vld;
    int          stall_pct, extra;
    bit          prev_req, prev_gnt, prev_wen;
    logic [31:0] prev_add, prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
    endfunction

    // One clock cycle: drive inputs at negedge, check outputs, advance the model for the coming edge.
    task automatic step(input bit st, input bit spur);
        bit   done_exp, busy_exp, issuing, exp_req, hs, has_rsp;
        rsp_t r;
        int   a;
        start   = st;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        has_rsp = 1'b0;
        r       = '{0, 32'h0, 1'b0, 0};
        if (spur) begin
            rvalid = 1'b1;
            rdata  = $urandom;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            r       = rq.pop_front();
            has_rsp = 1'b1;
            rvalid  = 1'b1;
            rdata   = r.dat;
        end
        gnt = ($urandom_range(0, 99) >= stall_pct);
        #1;
        done_exp = run && rd_hs == N && outst == 0;
        busy_exp = run && !done_exp;
        issuing  = busy_exp && (wr_hs < N || (rd_hs < N && (rd_hs > 0 || outst == 0)));
        exp_req  = issuing && (outst < MO || rvalid);
        chk("busy", 32'(busy), 32'(busy_exp));
        chk("done", 32'(done), 32'(done_exp));
        chk("req", 32'(req), 32'(exp_req));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("first_err_addr", first_err, exp_first);
        if (req && exp_req) begin
            chk("be", 32'(be), 32'hF);
            if (wr_hs < N) begin
                chk("wr_wen", 32'(wen), 32'h0);
                chk("wr_add", add, BASE + 32'(4 * wr_hs));
                chk("wr_data", wdata, pat[wr_hs]);
            end else begin
                chk("rd_wen", 32'(wen), 32'h1);
                chk("rd_add", add, BASE + 32'(4 * rd_hs));
                chk("rd_data_out", wdata, 32'h0);
            end
        end
        if (req && prev_req && !prev_gnt) begin
            chk("stall_add", add, prev_add);
            chk("stall_wen", 32'(wen), 32'(prev_wen));
            chk("stall_data", wdata, prev_data);
        end
        hs = req && gnt;
        if (rvalid && busy_exp) begin
            if (outst == 0) begin
                if (exp_err < 16'hFFFF) exp_err++;
            end else begin
                outst--;
                if (has_rsp && r.rd && r.dat !== pat[r.idx]) begin
                    if (exp_err < 16'hFFFF) exp_err++;
                    if (!exp_first_vld) begin
                        exp_first     = BASE + 32'(4 * r.idx);
                        exp_first_vld = 1'b1;
                    end
                end
            end
        end
        if (hs) begin
            a = int'((add - BASE) >> 2);
            if (a >= 0 && a < N) begin
                if (!wen) begin
                    mem[a] = wdata;
                    if (wr_hs < 3) cap[wr_hs] = wdata;
                    rq.push_back('{cyc + 1 + extra, 32'h0, 1'b0, a});
                    wr_hs++;
                end else begin
                    rq.push_back('{cyc + 1 + extra, mem[a], 1'b1, a});
                    rd_hs++;
                end
            end
            outst++;
        end
        if (outst > max_out) max_out = outst;
        if (st && !busy_exp) begin
            run = 1'b1; wr_hs = 0; rd_hs = 0; outst = 0;
            exp_err = 0; exp_first = 32'h0; exp_first_vld = 1'b0;
        end
        prev_req  = req;
        prev_gnt  = gnt;
        prev_add  = add;
        prev_wen  = wen;
        prev_data = wdata;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        start  = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0; wr_hs = 0; rd_hs = 0; outst = 0;
        exp_err = 0; exp_first = 32'h0; exp_first_vld = 1'b0; prev_req = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);
        chk("rst_first", first_err, 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_add", add, 32'h0);
        chk("rst_wen", 32'(wen), 32'h0);
        chk("rst_be", 32'(be), 32'h0);
        chk("rst_data", wdata, 32'h0);
    endtask

    task automatic run_test(input string name, input int stall, input int ext, input bit corrupt,
                            input bit spur, input int rst_at, output int edges);
        bit sp, cor;
        int guard;
        stall_pct = stall;
        extra     = ext;
        edges     = 0;
        sp        = 1'b0;
        cor       = 1'b0;
        step(1'b1, 1'b0);
        guard = 0;
        while (!done && guard < 4000) begin
            if (rst_at > 0 && rd_hs >= rst_at) begin
                do_reset();
                return;
            end
            if (spur && !sp && run && wr_hs == N && rd_hs == 0 && outst == 0) begin
                step(1'b0, 1'b1);
                sp = 1'b1;
            end else begin
                step(1'b0, 1'b0);
            end
            edges++;
            guard++;
            if (corrupt && !cor && wr_hs == N) begin
                mem[3] = mem[3] ^ 32'h0000_0F0F;
                cor    = 1'b1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: done_o still 0 after %0d cycles, required 1", name, guard);
        end
    endtask

    initial begin
        int e;
        rst_n = 1'b0; start = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        stall_pct = 0; extra = 0; max_out = 0; run = 1'b0;
        pat[0] = SEED;
        for (int i = 1; i < N; i++) pat[i] = lfsr_next(pat[i-1]);
        for (int i = 0; i < N; i++) mem[i] = 32'h0;
        @(negedge clk);
        do_reset();

        // Zero stall, single-cycle latency: DONE lands at edge 2*N+2.
        run_test("zero_stall", 0, 0, 1'b0, 1'b0, 0, e);
        chk("done_edge", 32'(e), 32'd34);
        chk("wdata0", cap[0], 32'h0000_0001);
        chk("wdata1", cap[1], 32'h8020_0003);
        chk("wdata2", cap[2], 32'hC030_0002);
        chk("t1_err", 32'(err_cnt), 32'h0);

        run_test("stall50", 50, 0, 1'b0, 1'b0, 0, e);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_err", 32'(err_cnt), 32'h0);

        run_test("corrupt3", 30, 0, 1'b1, 1'b0, 0, e);
        chk("t3_err", 32'(err_cnt), 32'h1);
        chk("t3_first", first_err, 32'h0000_000C);

        max_out = 0;
        run_test("latency3", 0, 3, 1'b0, 1'b0, 0, e);
        chk("t4_max_out", 32'(max_out), 32'd4);
        chk("t4_err", 32'(err_cnt), 32'h0);

        run_test("spurious", 20, 0, 1'b0, 1'b1, 0, e);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_err", 32'(err_cnt), 32'h1);
        chk("t5_first", first_err, 32'h0);

        run_test("mid_read_reset", 25, 1, 1'b0, 1'b0, N / 2, e);
        repeat (10) step(1'b0, 1'b0);
        run_test("after_reset", 25, 1, 1'b0, 1'b0, 0, e);
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_err", 32'(err_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
